// File: rtl/siso_shift_ctrl.sv
// Parallel-to-serial controller: serializes a WIDTH-bit word MSB first into a
// DEPTH-stage SISO chain, then flushes zeros until the last data bit has left the chain.
module siso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int MAXC = (WIDTH > DEPTH) ? WIDTH : DEPTH;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    // Outputs depend only on state and shreg, except hold gating shift_en.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        shift_en = 1'b0;
        ser_out  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    shreg_n = in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                ser_out  = shreg[WIDTH-1];
                shift_en = ~hold;
                if (!hold) begin
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    if (cnt == LAST_BIT) begin
                        cnt_n   = '0;
                        state_n = FLUSH;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            FLUSH: begin
                shift_en = ~hold;
                if (!hold) begin
                    if (cnt == LAST_FLUSH) begin
                        cnt_n   = '0;
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: serial bits are checked against a queue of expected
// bits filled at each accept; scenario tasks check handshake and done timing.
module tb_siso_shift_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             hold;
    logic             ser_out;
    logic             shift_en;
    logic             busy;
    logic             done;

    int   checks = 0;
    int   errors = 0;
    logic sb[$];
    logic e2e[$];
    logic [DEPTH-1:0] chain;

    siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .ser_out(ser_out),
        .shift_en(shift_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream SISO chain driven by the controller
    always @(posedge clk) begin
        if (!rst) chain <= '0;
        else if (shift_en) chain <= {chain[DEPTH-2:0], ser_out};
    end

    // Every enabled cycle consumes one expected serial bit
    always @(negedge clk) begin
        if (shift_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_underflow: got ser_out=%b, required no enabled cycle", ser_out);
            end else begin
                logic exp_bit;
                exp_bit = sb.pop_front();
                if (ser_out !== exp_bit) begin
                    errors++;
                    $display("[TB] FAIL sb_ser_out: got %b, required %b", ser_out, exp_bit);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(d[i]);
        for (int i = 0; i < DEPTH; i++) sb.push_back(1'b0);
    endtask

    // Leaves the bench in cycle 1 (first SHIFT cycle) of the new word
    task automatic send_word(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        push_word(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_done_cycle(input string name);
        checks++;
        if (done !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: got done=%b shift_en=%b busy=%b, required 1 0 1", name, done, shift_en, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d bits left, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hFF; hold = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, busy, done, shift_en, ser_out} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, required 10000", {in_ready, busy, done, shift_en, ser_out});
        end
        in_valid = 1'b0; hold = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic;
        send_word(8'hA5);
        for (int k = 1; k <= WIDTH + DEPTH; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || shift_en !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d: got busy=%b done=%b shift_en=%b in_ready=%b, required 1 0 1 0",
                         k, busy, done, shift_en, in_ready);
            end
            tick();
        end
        check_done_cycle("basic_done13");
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_ready14: got in_ready=%b done=%b busy=%b, required 1 0 0", in_ready, done, busy);
        end
    endtask

    task automatic test_hold;
        send_word(8'hFF);
        for (int k = 1; k <= WIDTH + DEPTH + 3; k++) begin
            logic held;
            held = (k >= 5 && k <= 7);
            hold = held;
            #1;
            checks++;
            if (shift_en !== ~held || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got shift_en=%b done=%b, required %b 0", k, shift_en, done, ~held);
            end
            tick();
        end
        hold = 1'b0;
        check_done_cycle("hold_done16");
        tick();
    endtask

    task automatic test_busy_ignore;
        send_word(8'h81);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int k = 1; k <= WIDTH + DEPTH; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_in_ready%0d: got %b, required 0", k, in_ready);
            end
            tick();
        end
        check_done_cycle("busy_done_81");
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready: got %b, required 1", in_ready);
        end
        push_word(8'h3C);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= WIDTH + DEPTH; k++) tick();
        check_done_cycle("busy_done_3c");
        tick();
    endtask

    task automatic test_mid_reset;
        logic saw_done;
        send_word(8'hB7);
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b0; in_valid = 1'b1; hold = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_idle: got in_ready=%b shift_en=%b busy=%b, required 1 0 0", in_ready, shift_en, busy);
        end
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
        sb.delete();
        saw_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (done !== 1'b0) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got done pulse=%b, required 0", saw_done);
        end
        send_word(8'h6E);
        for (int k = 1; k <= WIDTH + DEPTH; k++) tick();
        check_done_cycle("midreset_new_done");
        tick();
    endtask

    task automatic test_end_to_end;
        logic [WIDTH-1:0] w;
        w = 8'hC3;
        for (int i = WIDTH - 1; i >= 0; i--) e2e.push_back(w[i]);
        send_word(w);
        for (int k = 1; k <= WIDTH + DEPTH; k++) begin
            if (k > DEPTH) begin
                logic exp_bit;
                exp_bit = e2e.pop_front();
                checks++;
                if (chain[DEPTH-1] !== exp_bit || shift_en !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL e2e_sout%0d: got sout=%b shift_en=%b, required %b 1", k, chain[DEPTH-1], shift_en, exp_bit);
                end
            end
            tick();
        end
        check_done_cycle("e2e_done");
        checks++;
        if (e2e.size() != 0) begin
            errors++;
            $display("[TB] FAIL e2e_drain: got %0d bits left, required 0", e2e.size());
        end
        tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_busy_ignore();
        test_mid_reset();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
